trig_ringbuffer: RTL and testbench
==================================

# trig_ringbuffer

Multi-channel, triggered successor to the single-channel PMT ring buffer. It continuously records NCH ADC channels into a circular store. On an external trigger it captures a programmable pre-trigger and post-trigger window, then freezes and streams that window out over a valid/ready interface. It sits between the ADC capture front end and the event readout/packetiser.

## Interface
- SIZE, 12: address bits; depth NUMWORDS = 2**SIZE samples per channel.
- WIDTH, 14: bits per channel sample.
- NCH, 4: channels, stored and read in parallel (one word = NCH*WIDTH bits, channel 0 in LSBs).
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  sample strobe; din valid this cycle.
- din  in  NCH*WIDTH  sample word.
- arm  in  1  single-cycle request to arm; honoured only in IDLE.
- trig  in  1  trigger; sampled only when wr_en=1 in ARMED.
- pre_len  in  SIZE  requested samples before the trigger sample; latched on arm.
- post_len  in  SIZE  requested samples from the trigger sample onward; latched on arm; 0 treated as 1.
- rd_ready  in  1  consumer accepts dout.
- dout  out  NCH*WIDTH  window word.
- dout_valid  out  1  dout holds a valid word.
- dout_last  out  1  final word of the window, qualified by dout_valid.
- trig_addr  out  SIZE  store address of the trigger sample; valid from POST entry until next arm.
- pretrig_short  out  1  fewer than pre_len pre-trigger samples available.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ARMED, POST, READOUT.
- IDLE: writes continue. trig is ignored. arm latches pre_len and post_len, clears the since-arm counter and pretrig_short, and moves to ARMED.
- ARMED: each wr_en writes din at wptr, then wptr+1 (mod NUMWORDS). A saturating since-arm counter (SIZE+1 bits, max NUMWORDS) increments per write. wr_en&trig marks that sample as the trigger: trig_addr<=wptr, post counter=1. If post_eff=1, go to READOUT; else go to POST.
- POST: writes continue. Each write increments the post counter. The write that reaches post_eff moves to READOUT.
- Window computation, done at trigger, in SIZE+1-bit arithmetic:
  - post_eff = max(post_len,1).
  - pre_eff = min(pre_len, since-arm count excluding trigger sample, NUMWORDS-post_eff).
  - pretrig_short = 1 only if the since-arm count was the limiting term.
  - L = pre_eff + post_eff (never exceeds NUMWORDS).
  - start = trig_addr - pre_eff, mod NUMWORDS (wraps naturally).
- READOUT: store frozen; wr_en ignored, memory and wptr unchanged. Emits L words from addresses start, start+1, ... mod NUMWORDS. dout_last is asserted with word L-1. After its transfer, go to IDLE.
- arm outside IDLE and trig outside ARMED have no effect.
- Memory is synchronous read, 1-cycle latency. An output/skid register is required so that no word is lost or duplicated under any rd_ready pattern.

## Timing
- Reset (async assert, sync release): state IDLE; wptr 0; counters 0; dout 0; dout_valid 0; dout_last 0; trig_addr 0; pretrig_short 0; busy 0. Memory contents undefined. Reset at any point, including mid-POST or mid-READOUT, aborts the window.
- busy rises the cycle after arm is accepted and falls the cycle after the last transfer.
- Write to READOUT: READOUT is entered the cycle after the write that completes post_eff.
- First dout_valid: no later than 2 cycles after READOUT entry.
- Transfer: a word transfers when dout_valid&rd_ready. While dout_valid&!rd_ready, dout and dout_last are held stable.
- Throughput: with rd_ready held at 1, one word per cycle; L words complete in at most L+2 cycles.
- trig arriving on the same cycle as the arm-accept is ignored (the block is still in IDLE).

## Test plan
- Basic window: SIZE=4, NCH=2, WIDTH=8; ch0=n, ch1=n+128. Arm, write n=0..19, trig at n=10, pre=3, post=4 -> 7 words, ch0=7..13, dout_last on 13, trig_addr=10 mod 16=10, pretrig_short=0.
- Wrap-around: trigger written at address 1, pre=4, post=2 -> read addresses 13,14,15,0,1,2 in order.
- Short pretrigger: arm, trig on 2nd write after arm, pre=5, post=3 -> pre_eff=1, 4 words, pretrig_short=1.
- Clamp: SIZE=4, pre=12, post=8, long pre-history -> pre_eff=8, L=16, 16 distinct words ending at trigger+7.
- Backpressure/freeze: rd_ready pattern 1,0,1,0,0,1... with wr_en=1 throughout READOUT -> exact window sequence, dout stable while stalled, a subsequent window shows memory untouched during READOUT.
- Reset mid-POST: drop rst_n for 1 cycle -> all outputs 0, IDLE; trig ignored until the next arm.

Source files
------------

// File: rtl/trig_ringbuffer.sv
// Triggered multi-channel circular sample store: records NCH channels continuously,
// captures a pre/post-trigger window on trig, then freezes and streams it out.
module trig_ringbuffer #(
    parameter int SIZE  = 12,
    parameter int WIDTH = 14,
    parameter int NCH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [NCH*WIDTH-1:0]  din,
    input  logic                  arm,
    input  logic                  trig,
    input  logic [SIZE-1:0]       pre_len,
    input  logic [SIZE-1:0]       post_len,
    input  logic                  rd_ready,
    output logic [NCH*WIDTH-1:0]  dout,
    output logic                  dout_valid,
    output logic                  dout_last,
    output logic [SIZE-1:0]       trig_addr,
    output logic                  pretrig_short,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    localparam int              W       = NCH * WIDTH;
    localparam int              DEPTH_I = 1 << SIZE;
    localparam logic [SIZE:0]   DEPTH   = {1'b1, {SIZE{1'b0}}};
    localparam logic [SIZE:0]   ONE_W   = 1;
    localparam logic [SIZE-1:0] ONE_A   = 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_POST    = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    state_t          state;
    logic [SIZE-1:0] wptr;
    logic [SIZE:0]   since_cnt;
    logic [SIZE:0]   post_cnt;
    logic [SIZE-1:0] pre_l;
    logic [SIZE-1:0] post_l;
    logic [SIZE:0]   post_eff_q;
    logic [SIZE:0]   win_len;
    logic [SIZE-1:0] rd_addr;
    logic [SIZE:0]   rd_idx;
    logic            rd_pend;
    logic            rd_pend_last;
    logic [W-1:0]    mem_q;
    logic [W-1:0]    skid;
    logic            skid_valid;
    logic            skid_last;

    logic [W-1:0]    mem [DEPTH_I];

    logic [SIZE:0]   post_eff_c;
    logic [SIZE:0]   cap_c;
    logic [SIZE:0]   pre_req_c;
    logic [SIZE:0]   pre_lim_c;
    logic [SIZE:0]   pre_eff_c;
    logic            short_c;
    logic            mem_we;
    logic            pop;
    logic [1:0]      occ;
    logic            issue;

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // Window sizing from the latched request and the samples seen since arm.
    always_comb begin
        post_eff_c = (post_l == '0) ? ONE_W : {1'b0, post_l};
        cap_c      = DEPTH - post_eff_c;
        pre_req_c  = {1'b0, pre_l};
        pre_lim_c  = (pre_req_c < cap_c) ? pre_req_c : cap_c;
        short_c    = (since_cnt < pre_lim_c);
        pre_eff_c  = short_c ? since_cnt : pre_lim_c;
    end

    // Output handshake: a word moves on any edge where dout_valid && rd_ready;
    // while dout_valid is high and rd_ready low, dout and dout_last hold.
    // Reads are issued only while output register + skid + in-flight read
    // leave room, so a returning read always has a slot to land in.
    always_comb begin
        mem_we = wr_en && (state != S_READOUT);
        pop    = dout_valid && rd_ready;
        occ    = {1'b0, dout_valid} + {1'b0, skid_valid} + {1'b0, rd_pend};
        issue  = (state == S_READOUT) && (rd_idx < win_len)
                 && ((occ - {1'b0, pop}) < 2'd2);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr] <= din;
        end
        mem_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            wptr          <= '0;
            since_cnt     <= '0;
            post_cnt      <= '0;
            pre_l         <= '0;
            post_l        <= '0;
            post_eff_q    <= '0;
            win_len       <= '0;
            rd_addr       <= '0;
            rd_idx        <= '0;
            trig_addr     <= '0;
            pretrig_short <= 1'b0;
        end else begin
            if (mem_we) begin
                wptr <= wptr + ONE_A;
            end
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        pre_l         <= pre_len;
                        post_l        <= post_len;
                        since_cnt     <= '0;
                        pretrig_short <= 1'b0;
                        state         <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (wr_en && trig) begin
                        trig_addr     <= wptr;
                        post_cnt      <= ONE_W;
                        post_eff_q    <= post_eff_c;
                        win_len       <= pre_eff_c + post_eff_c;
                        rd_addr       <= wptr - pre_eff_c[SIZE-1:0];
                        rd_idx        <= '0;
                        pretrig_short <= short_c;
                        state         <= (post_eff_c == ONE_W) ? S_READOUT : S_POST;
                    end else if (wr_en && (since_cnt != DEPTH)) begin
                        since_cnt <= since_cnt + ONE_W;
                    end
                end
                S_POST: begin
                    if (wr_en) begin
                        post_cnt <= post_cnt + ONE_W;
                        if ((post_cnt + ONE_W) == post_eff_q) begin
                            state <= S_READOUT;
                        end
                    end
                end
                S_READOUT: begin
                    if (issue) begin
                        rd_addr <= rd_addr + ONE_A;
                        rd_idx  <= rd_idx + ONE_W;
                    end
                    if (pop && dout_last) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            dout         <= '0;
            dout_valid   <= 1'b0;
            dout_last    <= 1'b0;
            skid         <= '0;
            skid_valid   <= 1'b0;
            skid_last    <= 1'b0;
        end else begin
            rd_pend      <= issue;
            rd_pend_last <= issue && (rd_idx == (win_len - ONE_W));
            if (pop) begin
                if (skid_valid) begin
                    dout       <= skid;
                    dout_last  <= skid_last;
                    skid_valid <= rd_pend;
                    if (rd_pend) begin
                        skid      <= mem_q;
                        skid_last <= rd_pend_last;
                    end
                end else if (rd_pend) begin
                    dout      <= mem_q;
                    dout_last <= rd_pend_last;
                end else begin
                    dout_valid <= 1'b0;
                    dout_last  <= 1'b0;
                end
            end else if (rd_pend) begin
                if (!dout_valid) begin
                    dout       <= mem_q;
                    dout_last  <= rd_pend_last;
                    dout_valid <= 1'b1;
                end else begin
                    skid       <= mem_q;
                    skid_last  <= rd_pend_last;
                    skid_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_trig_ringbuffer.sv
// Self-checking bench for trig_ringbuffer: a reference store model predicts each
// captured window into an expected queue that the output monitor drains.
module tb_trig_ringbuffer;

    localparam int SIZE  = 4;
    localparam int WIDTH = 8;
    localparam int NCH   = 2;
    localparam int W     = NCH * WIDTH;
    localparam int DEPTH = 1 << SIZE;

    logic            clk;
    logic            rst_n;
    logic            wr_en;
    logic [W-1:0]    din;
    logic            arm;
    logic            trig;
    logic [SIZE-1:0] pre_len;
    logic [SIZE-1:0] post_len;
    logic            rd_ready;
    logic [W-1:0]    dout;
    logic            dout_valid;
    logic            dout_last;
    logic [SIZE-1:0] trig_addr;
    logic            pretrig_short;
    logic            busy;
    logic [1:0]      state_dbg;

    trig_ringbuffer #(.SIZE(SIZE), .WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .arm(arm), .trig(trig),
        .pre_len(pre_len), .post_len(post_len), .rd_ready(rd_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
        .trig_addr(trig_addr), .pretrig_short(pretrig_short), .busy(busy),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // reference model of the store and window rules
    logic [W:0]   exp_q[$];
    logic [W-1:0] m_mem [DEPTH];
    int m_wptr = 0, m_since = 0, m_state = 0;
    int m_pre = 0, m_post = 0, m_post_eff = 0, m_pcnt = 0;
    int m_tidx = 0, m_pe = 0, m_len = 0, m_short = 0;
    int sample_n = 0;

    function automatic logic [W-1:0] mk_word(input int n);
        logic [7:0] c0, c1;
        c0 = 8'(n);
        c1 = 8'(n + 128);
        return {c1, c0};
    endfunction

    task automatic push_window();
        int addr;
        for (int k = 0; k < m_len; k++) begin
            addr = (m_tidx - m_pe + k + DEPTH) % DEPTH;
            exp_q.push_back({(k == m_len - 1), m_mem[addr]});
        end
        m_state = 3;
    endtask

    task automatic model_write(input logic [W-1:0] w, input bit t);
        int cap, lim;
        if (m_state == 3) return;
        m_mem[m_wptr] = w;
        if (m_state == 1) begin
            if (t) begin
                m_post_eff = (m_post == 0) ? 1 : m_post;
                cap        = DEPTH - m_post_eff;
                lim        = (m_pre < cap) ? m_pre : cap;
                m_pe       = (m_since < lim) ? m_since : lim;
                m_short    = (m_since < m_pre && m_since < cap) ? 1 : 0;
                m_tidx     = m_wptr;
                m_len      = m_pe + m_post_eff;
                m_pcnt     = 1;
                if (m_pcnt == m_post_eff) push_window();
                else m_state = 2;
            end else if (m_since < DEPTH) begin
                m_since++;
            end
        end else if (m_state == 2) begin
            m_pcnt++;
            if (m_pcnt == m_post_eff) push_window();
        end
        m_wptr = (m_wptr + 1) % DEPTH;
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_sample(input bit t);
        logic [W-1:0] w;
        w = mk_word(sample_n);
        sample_n++;
        wr_en = 1'b1; din = w; trig = t;
        model_write(w, t);
        step();
        wr_en = 1'b0; trig = 1'b0;
    endtask

    task automatic do_arm(input int pre, input int post, input bit with_wr_trig);
        logic [W-1:0] w;
        arm = 1'b1; pre_len = SIZE'(pre); post_len = SIZE'(post);
        if (with_wr_trig) begin
            w = mk_word(sample_n);
            sample_n++;
            wr_en = 1'b1; din = w; trig = 1'b1;
            model_write(w, 1'b0);
        end
        m_state = 1; m_since = 0; m_pre = pre; m_post = post;
        step();
        arm = 1'b0; wr_en = 1'b0; trig = 1'b0;
        check("busy_after_arm", busy, 1);
        check("armed_state", state_dbg, 1);
    endtask

    // mode 0: always ready, 1: random, 2: 1,0,1,0,0,1 pattern
    task automatic run_readout(input string tag, input int mode, input bit junk_wr);
        int cyc;
        bit pat[6];
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        check({tag, "_trig_addr"}, trig_addr, m_tidx);
        check({tag, "_pretrig_short"}, pretrig_short, m_short);
        cyc = 0;
        while (cyc < 300) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = 1'($urandom_range(0, 1));
                default: rd_ready = pat[cyc % 6];
            endcase
            if (junk_wr) begin
                wr_en = 1'b1;
                din   = W'($urandom_range(0, 65535));
                trig  = 1'($urandom_range(0, 1));
            end
            step();
            cyc++;
            if (!busy) break;
        end
        wr_en = 1'b0; trig = 1'b0; rd_ready = 1'b1;
        check({tag, "_done"}, busy, 0);
        check({tag, "_leftover"}, exp_q.size(), 0);
        if (mode == 0) check({tag, "_cycles_within_L_plus_2"}, (cyc <= m_len + 2), 1);
        m_state = 0;
        exp_q.delete();
    endtask

    // scoreboard monitor: compare each transfer, and hold stability while stalled
    bit           hold_pending = 1'b0;
    logic [W+1:0] hold_val;
    logic [W:0]   exp_word;

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pending)
                check("hold_stable", {dout_valid, dout_last, dout}, hold_val);
            if (dout_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", dout_valid, 1'b0);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("dout_data", dout, exp_word[W-1:0]);
                    check("dout_last", dout_last, exp_word[W]);
                end
            end
            hold_pending = dout_valid && !rd_ready;
            hold_val     = {dout_valid, dout_last, dout};
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; din = '0; arm = 1'b0; trig = 1'b0;
        pre_len = '0; post_len = '0; rd_ready = 1'b1;
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_trig_addr", trig_addr, 0);
        rst_n = 1'b1;
        step();

        // basic window: trig at n=10, pre 3, post 4 -> ch0 7..13
        do_arm(3, 4, 1'b0);
        for (int n = 0; n < 14; n++) write_sample(n == 10);
        check("basic_len", m_len, 7);
        check("basic_first_ch0", exp_q[0][7:0], 7);
        check("basic_trig_addr_const", trig_addr, 10);
        run_readout("basic", 0, 1'b0);

        // wrap-around: trigger lands at address 1 with full pre-history
        do_arm(4, 2, 1'b0);
        for (int k = 0; k < 4 || m_wptr != 1; k++) write_sample(1'b0);
        write_sample(1'b1);
        write_sample(1'b0);
        check("wrap_trig_addr_const", trig_addr, 1);
        run_readout("wrap", 1, 1'b0);

        // short pretrigger; trig on the arm cycle is ignored
        do_arm(5, 3, 1'b1);
        write_sample(1'b0);
        write_sample(1'b1);
        write_sample(1'b0);
        write_sample(1'b0);
        check("short_len", m_len, 4);
        run_readout("short", 0, 1'b0);

        // clamp: pre 12 + post 8 exceeds the store
        do_arm(12, 8, 1'b0);
        for (int k = 0; k < 20; k++) write_sample(1'b0);
        for (int k = 0; k < 8; k++) write_sample(k == 0);
        check("clamp_len", m_len, 16);
        run_readout("clamp", 0, 1'b0);

        // backpressure with writes hammering during readout
        do_arm(2, 3, 1'b0);
        for (int k = 0; k < 5; k++) write_sample(1'b0);
        for (int k = 0; k < 3; k++) write_sample(k == 0);
        run_readout("bp", 2, 1'b1);

        // follow-up window: write pointer and store untouched by readout
        do_arm(6, 2, 1'b0);
        for (int k = 0; k < 8; k++) write_sample(1'b0);
        for (int k = 0; k < 2; k++) write_sample(k == 0);
        run_readout("after_bp", 1, 1'b0);

        // reset mid-POST aborts the window
        do_arm(2, 5, 1'b0);
        for (int k = 0; k < 4; k++) write_sample(1'b0);
        write_sample(1'b1);
        write_sample(1'b0);
        rst_n = 1'b0;
        #2;
        check("midrst_busy", busy, 0);
        check("midrst_state", state_dbg, 0);
        check("midrst_dout_valid", dout_valid, 0);
        check("midrst_dout_last", dout_last, 0);
        check("midrst_trig_addr", trig_addr, 0);
        check("midrst_pretrig_short", pretrig_short, 0);
        step();
        rst_n = 1'b1;
        exp_q.delete();
        m_state = 0; m_wptr = 0; m_since = 0;
        for (int k = 0; k < 4; k++) begin
            write_sample(1'b1);
            check("trig_ignored_idle", busy, 0);
        end

        // recovery window after reset
        do_arm(3, 3, 1'b0);
        for (int k = 0; k < 6; k++) write_sample(1'b0);
        for (int k = 0; k < 3; k++) write_sample(k == 0);
        run_readout("recover", 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
